next_pc_unit: RTL
=================

# next_pc_unit

Next-PC sequencer and status-flag register that sits directly downstream of the main instruction decoder. It consumes the decoder's branch/jump strobes (beq, brv, jmxor, blezal, balv, jalpc) plus ALU flags and register operands. It holds the program counter, the Z/N/V status register and the $31 link request. It contains a two-state FSM that turns jmxor into a two-cycle memory-indirect jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_PC, 32'h0000_0080, PC loaded on misaligned target (only with the macro in Configuration)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- pc_en  in  1  advance enable; 0 = hold PC, status and FSM
- rformat  in  1  R-format qualifier from decoder (regdest)
- branch, brvsig, jmxorsig, blezalsig, balvsig, jalpcsig  in  1 each  decoder strobes
- flag_we  in  1  status update enable (decoder regwrite)
- alu_zero, alu_neg, alu_ovf  in  1 each  current ALU flags
- imm  in  16  instruction immediate
- jtarget  in  26  instruction jump field
- rs_data, rt_data  in  32  register-file read data
- dmem_rdata  in  32  data-memory read data
- pc  out  32  current PC (registered)
- pc_plus4  out  32  pc+4
- link_we  out  1  write pc_plus4 to $31 this cycle
- link_data  out  32  equals pc_plus4
- jmx_rd  out  1  data-memory read request for jmxor
- jmx_addr  out  32  rs_data ^ rt_data
- stall_out  out  1  fetch must hold current instruction
- status  out  3  {Z,N,V} registered flags

## Operation
- brv and jmxor are effective only when rformat=1. All other strobes are used as given.
- Offsets:
  - bt = pc_plus4 + (sign_ext(imm) << 2), modulo 2^32; wrap-around is legal.
  - jt = {pc_plus4[31:28], jtarget, 2'b00}.
- Next PC in RUN, first match wins:
  1. jmxor: PC holds; jmx_rd=1; stall_out=1; go to JMX_WAIT.
  2. brv: if status.V then rs_data.
  3. balv: if status.V then jt, with link.
  4. blezal: if status.Z|status.N then bt, with link.
  5. jalpc: bt unconditionally, with link.
  6. beq: if alu_zero then bt.
  7. Otherwise pc_plus4.
- A strobe whose condition is false selects pc_plus4 and does not link.
- link_we is combinational: pc_en & RUN & linking branch taken.
- Status register: on the clock edge with pc_en & RUN & flag_we, it loads {alu_zero, alu_neg, alu_ovf}. A branch in the same cycle evaluates the old flags.
- FSM states:
  - RUN → JMX_WAIT on jmxor & pc_en.
  - JMX_WAIT → RUN on pc_en, loading PC ← dmem_rdata.
  - In JMX_WAIT: stall_out=1, jmx_rd=1, jmx_addr held from a register captured at entry, status frozen, link_we=0.
- Reset values: pc=RESET_PC, status=3'b000, state=RUN, link_we=0, jmx_rd=0, stall_out=0.
- Reset asserted mid-JMX_WAIT abandons the jump immediately.

## Timing
- PC, status and FSM update on the rising clk edge. Next-PC selection is combinational from current inputs, giving one cycle of latency from strobe to new pc.
- jmxor takes exactly 2 cycles with pc_en held at 1. The cycle after the second edge shows pc = dmem_rdata.
- dmem_rdata must be valid in the JMX_WAIT cycle, i.e. synchronous memory with 1-cycle read latency.
- pc_en=0 freezes every register and forces link_we=0. stall_out still reflects the current state.

## Configuration
- PC_MISALIGN_CHECK_EN defined:
  - Any selected target with bits [1:0] ≠ 0 (brv, jmxor data) loads TRAP_PC instead.
  - That jump's link is suppressed.
  - status.V is set on the same edge.
- Macro undefined: targets are loaded unchanged; no trap logic is generated.

## Structure
- Shared package cpu_defs holds:
  - FSM state encodings (RUN=1'b0, JMX_WAIT=1'b1)
  - status bit indices (Z=2, N=1, V=0)
  - default RESET_PC/TRAP_PC constants
  - the branch-priority order
- One sub-module, status_reg: the 3-bit flag register with its write enable and async reset.

## Test plan
- Reset with RESET_PC=0: pc=0, status=000. 3 cycles of no strobes with pc_en=1 → pc = 4, 8, 12.
- pc=0x100, branch=1, imm=16'hFFFF, alu_zero=1 → pc=0x100 next cycle. Same with alu_zero=0 → pc=0x104.
- flag_we with alu_ovf=1, then balvsig with jtarget=26'h40 → pc={0x0,0x40,00}=0x100, link_we=1, link_data=old pc+4.
- rformat=1, jmxorsig=1, rs=0xF0, rt=0x0F → jmx_addr=0xFF and stall_out=1 for 2 cycles. dmem_rdata=0x200 → pc=0x200, no link.
- blezal with status Z=0, N=0 → pc+4, link_we=0. With N=1 → bt, link_we=1. Same cycle as flag_we → old flags used.
- With PC_MISALIGN_CHECK_EN: brv taken with rs=0x102 → pc=0x80, status.V=1, link_we=0.

Source files
------------

// File: rtl/next_pc_unit_pkg.sv
// Shared definitions for the next-PC sequencer: FSM encoding, status bit
// positions, default vectors and the branch-priority order.
package cpu_defs;

    typedef enum logic {
        RUN      = 1'b0,
        JMX_WAIT = 1'b1
    } pc_state_t;

    localparam int STAT_Z = 2;
    localparam int STAT_N = 1;
    localparam int STAT_V = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0080;

    // Enumerators are listed highest priority first.
    typedef enum logic [2:0] {
        SEL_JMX,
        SEL_BRV,
        SEL_BALV,
        SEL_BLEZAL,
        SEL_JALPC,
        SEL_BEQ,
        SEL_SEQ
    } pc_sel_t;

    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [15:0] offset);
        return base + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_unit_status_reg.sv
// Three-bit {Z,N,V} status flag register with write enable and async reset.
module status_reg
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] d,
    output logic [2:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 3'b000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC sequencer with status flags and a two-cycle memory-indirect jump.
// Optional macro PC_MISALIGN_CHECK_EN redirects misaligned targets to TRAP_PC.
module next_pc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic        rformat,
    input  logic        branch,
    input  logic        brvsig,
    input  logic        jmxorsig,
    input  logic        blezalsig,
    input  logic        balvsig,
    input  logic        jalpcsig,
    input  logic        flag_we,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic [15:0] imm,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        jmx_rd,
    output logic [31:0] jmx_addr,
    output logic        stall_out,
    output logic [2:0]  status
);

    pc_state_t   state, state_next;
    pc_sel_t     sel;
    logic [31:0] pc_q, jmx_addr_q;
    logic [31:0] bt, jt, target, pc_next;
    logic        jmx_req, brv_req, link_req, trap_hit;
    logic        in_run, in_wait;
    logic        status_we;
    logic [2:0]  status_d;

    assign in_run   = (state == RUN);
    assign in_wait  = (state == JMX_WAIT);
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign link_data = pc_plus4;
    assign bt       = branch_target(pc_plus4, imm);
    assign jt       = {pc_plus4[31:28], jtarget, 2'b00};
    assign jmx_req  = rformat & jmxorsig;
    assign brv_req  = rformat & brvsig;

    // The first asserted strobe owns the cycle; if its condition fails the
    // sequencer falls through to pc_plus4 rather than to a lower strobe.
    always_comb begin
        sel = SEL_SEQ;
        if (jmx_req) begin
            sel = SEL_JMX;
        end else if (brv_req) begin
            sel = status[STAT_V] ? SEL_BRV : SEL_SEQ;
        end else if (balvsig) begin
            sel = status[STAT_V] ? SEL_BALV : SEL_SEQ;
        end else if (blezalsig) begin
            sel = (status[STAT_Z] | status[STAT_N]) ? SEL_BLEZAL : SEL_SEQ;
        end else if (jalpcsig) begin
            sel = SEL_JALPC;
        end else if (branch) begin
            sel = alu_zero ? SEL_BEQ : SEL_SEQ;
        end
    end

    always_comb begin
        target   = pc_plus4;
        link_req = 1'b0;
        case (sel)
            SEL_JMX:    target = pc_q;
            SEL_BRV:    target = rs_data;
            SEL_BALV:   begin target = jt; link_req = 1'b1; end
            SEL_BLEZAL: begin target = bt; link_req = 1'b1; end
            SEL_JALPC:  begin target = bt; link_req = 1'b1; end
            SEL_BEQ:    target = bt;
            default:    target = pc_plus4;
        endcase
        if (in_wait) begin
            target   = dmem_rdata;
            link_req = 1'b0;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    assign trap_hit = (target[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    assign pc_next   = trap_hit ? TRAP_PC : target;
    assign link_we   = pc_en & in_run & link_req & ~trap_hit;
    assign stall_out = in_wait | (in_run & jmx_req);
    assign jmx_rd    = stall_out;
    assign jmx_addr  = in_wait ? jmx_addr_q : (rs_data ^ rt_data);

    // A trap forces V even while the flags are otherwise frozen.
    always_comb begin
        status_d = status;
        if (in_run && flag_we) begin
            status_d = {alu_zero, alu_neg, alu_ovf};
        end
        if (trap_hit) begin
            status_d[STAT_V] = 1'b1;
        end
    end

    assign status_we = pc_en & ((in_run & flag_we) | trap_hit);

    status_reg u_status_reg (
        .clk   (clk),
        .reset (reset),
        .we    (status_we),
        .d     (status_d),
        .q     (status)
    );

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (jmx_req) state_next = JMX_WAIT;
            JMX_WAIT: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pc_q       <= RESET_PC;
            jmx_addr_q <= 32'h0;
        end else if (pc_en) begin
            state <= state_next;
            pc_q  <= pc_next;
            if (in_run && jmx_req) begin
                jmx_addr_q <= rs_data ^ rt_data;
            end
        end
    end

endmodule
